// File: rtl/sh7034_wdt_if.sv
// IBUS port bundle shared by the SH7034 on-chip peripherals (watchdog timer here).
interface sh7034_wdt_if;
    // Handshake: an access exists in a phi cycle while IBUS_REQ is high. Writes are
    // taken on CE_R and read data is registered on CE_F of the same phi cycle.
    // IBUS_BUSY is tied low, so every access completes in the phi cycle it is issued.
    logic [27:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (
        output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        input  IBUS_DO, IBUS_BUSY, IBUS_ACT
    );

    modport slave (
        input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        output IBUS_DO, IBUS_BUSY, IBUS_ACT
    );
endinterface

// File: rtl/sh7034_wdt.sv
// SH7034 watchdog / interval timer: WTCSR, WTCNT, RSTCSR on the IBUS.
// Define SH7034_WDT_RESET_EN to enable the internal reset request (RSTE/RSTS, WDT_RST_N).
module sh7034_wdt #(
    parameter int RST_PULSE = 512,
    parameter int OVF_PULSE = 128
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    sh7034_wdt_if.slave ibus,
    output logic        WDT_IRQ,
    output logic        WDTOVF_N,
    output logic        WDT_RST_N
);
    localparam logic [27:0] REG_LO = 28'h5FFFFB8;
    localparam logic [27:0] REG_HI = 28'h5FFFFBB;
    localparam int          OW     = $clog2(OVF_PULSE + 1);

    logic        ovf, wt_it, tme;
    logic [2:0]  cks;
    logic [7:0]  wtcnt;
    logic [12:0] presc;
    logic        wovf;
    logic        rste, rsts;
    logic        rd_flag;
    logic        ovf_pend;
    logic [OW-1:0] ovf_cnt;

    logic        reg_sel, wr_acc, rd_acc, hi_half, lo_half;
    logic        wr_csr, wr_cnt, wr_wovf_clr;
    logic [3:0]  tap_idx;
    logic [12:0] presc_inc;
    logic        tick, cnt_ovf;
    logic [7:0]  wtcsr_rd, rstcsr_rd;

    assign reg_sel        = (ibus.IBUS_A >= REG_LO) && (ibus.IBUS_A <= REG_HI);
    assign ibus.IBUS_ACT  = reg_sel;
    assign ibus.IBUS_BUSY = 1'b0;

    assign wr_acc  = ibus.IBUS_REQ & ibus.IBUS_WE & reg_sel;
    assign rd_acc  = ibus.IBUS_REQ & ~ibus.IBUS_WE & reg_sel;
    assign hi_half = (ibus.IBUS_BA[3:2] == 2'b11);
    assign lo_half = (ibus.IBUS_BA[1:0] == 2'b11);

    // Password in the upper byte of each halfword; byte writes never match a half.
    assign wr_csr      = wr_acc & hi_half & (ibus.IBUS_DI[31:24] == 8'hA5);
    assign wr_cnt      = wr_acc & hi_half & (ibus.IBUS_DI[31:24] == 8'h5A);
    assign wr_wovf_clr = wr_acc & lo_half & (ibus.IBUS_DI[15:0] == 16'hA500);

    always_comb begin
        tap_idx = 4'd0;
        case (cks)
            3'd0: tap_idx = 4'd0;
            3'd1: tap_idx = 4'd5;
            3'd2: tap_idx = 4'd6;
            3'd3: tap_idx = 4'd7;
            3'd4: tap_idx = 4'd8;
            3'd5: tap_idx = 4'd9;
            3'd6: tap_idx = 4'd11;
            default: tap_idx = 4'd12;
        endcase
    end

    // A WTCSR write restarts the prescaler, so no count is taken on that edge.
    assign presc_inc = presc + 13'd1;
    assign tick      = RES_N & tme & ~wr_csr & presc[tap_idx] & ~presc_inc[tap_idx];
    assign cnt_ovf   = tick & ~wr_cnt & (wtcnt == 8'hFF);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf   <= 1'b0;
            wt_it <= 1'b0;
            tme   <= 1'b0;
            cks   <= 3'd0;
            wtcnt <= 8'd0;
            presc <= 13'd0;
            wovf  <= 1'b0;
        end else if (CE_R) begin
            if (!RES_N) begin
                ovf   <= 1'b0;
                wt_it <= 1'b0;
                tme   <= 1'b0;
                cks   <= 3'd0;
                wtcnt <= 8'd0;
                presc <= 13'd0;
            end else begin
                if (wr_csr) begin
                    wt_it <= ibus.IBUS_DI[22];
                    tme   <= ibus.IBUS_DI[21];
                    cks   <= ibus.IBUS_DI[18:16];
                end
                ovf <= (cnt_ovf & ~wt_it)
                     | (ovf & ~(wr_csr & rd_flag & ~ibus.IBUS_DI[23]));
                if (wr_cnt)
                    wtcnt <= ibus.IBUS_DI[23:16];
                else if (tick)
                    wtcnt <= wtcnt + 8'd1;
                presc <= (wr_csr | ~tme) ? 13'd0 : presc_inc;
                wovf  <= (cnt_ovf & wt_it) | (wovf & ~wr_wovf_clr);
            end
        end
    end

    // OVF may only be cleared by a WTCSR write that follows a read which saw OVF=1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            rd_flag <= 1'b0;
        else if (CE_R && (!RES_N || wr_csr))
            rd_flag <= 1'b0;
        else if (CE_F && rd_acc && ibus.IBUS_BA[3] && ovf)
            rd_flag <= 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_pend <= 1'b0;
            ovf_cnt  <= '0;
        end else if (CE_R) begin
            ovf_pend <= cnt_ovf & wt_it;
            if (ovf_pend)
                ovf_cnt <= OW'(OVF_PULSE);
            else if (ovf_cnt != '0)
                ovf_cnt <= ovf_cnt - 1'b1;
        end
    end

    assign WDTOVF_N = (ovf_cnt == '0);

`ifdef SH7034_WDT_RESET_EN
    localparam int RW = $clog2(RST_PULSE + 1);
    logic          wr_rst;
    logic          rst_pend;
    logic [RW-1:0] rst_cnt;

    assign wr_rst = wr_acc & lo_half & (ibus.IBUS_DI[15:8] == 8'h5A);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rste <= 1'b0;
            rsts <= 1'b0;
        end else if (CE_R) begin
            if (!RES_N) begin
                rste <= 1'b0;
                rsts <= 1'b0;
            end else if (wr_rst) begin
                rste <= ibus.IBUS_DI[6];
                rsts <= ibus.IBUS_DI[5];
            end
        end
    end

    // Reset request is one-shot: an overflow during an active request is dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_pend <= 1'b0;
            rst_cnt  <= '0;
        end else if (CE_R) begin
            rst_pend <= cnt_ovf & wt_it & rste;
            if (rst_pend && rst_cnt == '0)
                rst_cnt <= RW'(RST_PULSE);
            else if (rst_cnt != '0)
                rst_cnt <= rst_cnt - 1'b1;
        end
    end

    assign WDT_RST_N = (rst_cnt == '0);
`else
    assign rste      = 1'b0;
    assign rsts      = 1'b0;
    assign WDT_RST_N = 1'b1;
`endif

    assign wtcsr_rd  = {ovf, wt_it, tme, 2'b11, cks};
    assign rstcsr_rd = {wovf, rste, rsts, 5'h1F};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            ibus.IBUS_DO <= 32'h0;
        else if (CE_F && rd_acc)
            ibus.IBUS_DO <= (ibus.IBUS_A[3:2] == 2'b10)
                          ? {wtcsr_rd, wtcnt, 8'hFF, rstcsr_rd} : 32'h0;
    end

    assign WDT_IRQ = ovf & ~wt_it;
endmodule

// File: tb/tb_sh7034_wdt.sv
// Directed plus randomized bench for sh7034_wdt, checked against a timeline-based reference model.
module tb_sh7034_wdt;
`ifdef SH7034_WDT_RESET_EN
    localparam bit RESET_EN = 1'b1;
`else
    localparam bit RESET_EN = 1'b0;
`endif
    localparam logic [27:0] A_CSR = 28'h5FFFFB8;
    localparam logic [27:0] A_RST = 28'h5FFFFBA;

    logic clk, rst_n, ce_r, ce_f, res_n;
    logic wdt_irq, wdtovf_n, wdt_rst_n;
    sh7034_wdt_if ibus ();

    sh7034_wdt dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CE_R      (ce_r),
        .CE_F      (ce_f),
        .RES_N     (res_n),
        .ibus      (ibus),
        .WDT_IRQ   (wdt_irq),
        .WDTOVF_N  (wdtovf_n),
        .WDT_RST_N (wdt_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: register fields, prescaler as a plain tick count, pulses as phi windows.
    int   m_phi;
    bit   m_ovf, m_wt, m_tme, m_rdflag, m_wovf, m_rste, m_rsts;
    int   m_cks, m_cnt, m_ticks;
    int   ovf_start, ovf_end, rst_start, rst_end;
    logic [31:0] m_do;
    logic [31:0] exp_q[$];
    int   div_tab [8] = '{2, 64, 128, 256, 512, 1024, 4096, 8192};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ovf = 0; m_wt = 0; m_tme = 0; m_rdflag = 0; m_wovf = 0; m_rste = 0; m_rsts = 0;
        m_cks = 0; m_cnt = 0; m_ticks = 0; m_do = 32'h0;
        ovf_start = 1; ovf_end = 0; rst_start = 1; rst_end = 0;
        exp_q.delete();
    endfunction

    function automatic bit in_range(input logic [27:0] a);
        return (a >= A_CSR) && (a <= 28'h5FFFFBB);
    endfunction

    function automatic logic [7:0] csr_byte();
        return {m_ovf, m_wt, m_tme, 2'b11, 3'(m_cks)};
    endfunction

    function automatic logic [7:0] rst_byte();
        return {m_wovf, m_rste, m_rsts, 5'h1F};
    endfunction

    function automatic void model_rise(input bit req, input bit we, input logic [27:0] a,
                                       input logic [3:0] ba, input logic [31:0] di, input bit rn);
        bit wr, wcsr, wcnt, wclr, wrst, hit, over, old_wt, old_rste, old_tme;
        m_phi++;
        if (!rn) begin
            m_ovf = 0; m_wt = 0; m_tme = 0; m_cks = 0; m_cnt = 0; m_ticks = 0;
            m_rste = 0; m_rsts = 0; m_rdflag = 0;
            return;
        end
        wr   = req && we && in_range(a);
        wcsr = wr && ba[3:2] == 2'b11 && di[31:24] == 8'hA5;
        wcnt = wr && ba[3:2] == 2'b11 && di[31:24] == 8'h5A;
        wclr = wr && ba[1:0] == 2'b11 && di[15:0] == 16'hA500;
        wrst = wr && ba[1:0] == 2'b11 && di[15:8] == 8'h5A;
        old_wt = m_wt; old_rste = m_rste; old_tme = m_tme;
        hit  = m_tme && !wcsr && ((m_ticks + 1) % div_tab[m_cks] == 0);
        over = hit && !wcnt && m_cnt == 255;
        if (wcnt) m_cnt = int'(di[23:16]);
        else if (hit) m_cnt = (m_cnt + 1) % 256;
        m_ticks = (wcsr || !old_tme) ? 0 : (m_ticks + 1) % 8192;
        if (wcsr) begin
            if (m_rdflag && !di[23]) m_ovf = 0;
            m_wt = di[22]; m_tme = di[21]; m_cks = int'(di[18:16]); m_rdflag = 0;
        end
        if (wclr) m_wovf = 0;
        if (wrst && RESET_EN) begin m_rste = di[6]; m_rsts = di[5]; end
        if (over && !old_wt) m_ovf = 1;
        if (over && old_wt) begin
            m_wovf = 1;
            if (m_phi > ovf_end) ovf_start = m_phi + 1;
            ovf_end = m_phi + 128;
            if (RESET_EN && old_rste && m_phi > rst_end) begin
                rst_start = m_phi + 1; rst_end = m_phi + 512;
            end
        end
    endfunction

    function automatic void model_fall(input bit req, input bit we, input logic [27:0] a,
                                       input logic [3:0] ba);
        if (req && !we && in_range(a)) begin
            exp_q.push_back({csr_byte(), 8'(m_cnt), 8'hFF, rst_byte()});
            if (ba[3] && m_ovf) m_rdflag = 1;
        end
    endfunction

    // One phi cycle: CE_R clock, then CE_F clock; entered and left at a negedge.
    task automatic phi(input bit req, input bit we, input logic [27:0] a,
                       input logic [3:0] ba, input logic [31:0] di, input bit rn);
        ibus.IBUS_REQ = req; ibus.IBUS_WE = we; ibus.IBUS_A = a;
        ibus.IBUS_BA = ba; ibus.IBUS_DI = di; res_n = rn;
        ce_r = 1'b1; ce_f = 1'b0;
        #1;
        chk("act", 32'(ibus.IBUS_ACT), 32'(in_range(a)));
        chk("busy", 32'(ibus.IBUS_BUSY), 32'h0);
        @(negedge clk);
        model_rise(req, we, a, ba, di, rn);
        chk("irq", 32'(wdt_irq), 32'(m_ovf & ~m_wt));
        chk("wdtovf_n", 32'(wdtovf_n), 32'(!(m_phi >= ovf_start && m_phi <= ovf_end)));
        chk("wdt_rst_n", 32'(wdt_rst_n), 32'(!(m_phi >= rst_start && m_phi <= rst_end)));
        ce_r = 1'b0; ce_f = 1'b1;
        @(negedge clk);
        model_fall(req, we, a, ba);
        if (exp_q.size() > 0) m_do = exp_q.pop_front();
        chk("do", ibus.IBUS_DO, m_do);
        ce_f = 1'b0; ibus.IBUS_REQ = 1'b0; ibus.IBUS_WE = 1'b0; res_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) phi(0, 0, A_CSR, 4'b0000, 32'h0, 1);
    endtask

    task automatic wr16(input logic [27:0] a, input logic [15:0] d);
        if (a[1]) phi(1, 1, a, 4'b0011, {16'h0, d}, 1);
        else      phi(1, 1, a, 4'b1100, {d, 16'h0}, 1);
    endtask

    task automatic rd();
        phi(1, 0, A_CSR, 4'b1111, 32'h0, 1);
    endtask

    int  lo_ovf, lo_rst, r;
    bit  stop, stopped, found;
    logic [7:0] rb;

    initial begin
        rst_n = 1'b0; ce_r = 1'b0; ce_f = 1'b0; res_n = 1'b1;
        ibus.IBUS_A = A_CSR; ibus.IBUS_DI = 32'h0; ibus.IBUS_BA = 4'h0;
        ibus.IBUS_WE = 1'b0; ibus.IBUS_REQ = 1'b0;
        model_reset(); m_phi = 0;
        repeat (3) @(negedge clk);
        chk("rst_irq", 32'(wdt_irq), 32'h0);
        chk("rst_wdtovf_n", 32'(wdtovf_n), 32'h1);
        chk("rst_wdt_rst_n", 32'(wdt_rst_n), 32'h1);
        chk("rst_do", ibus.IBUS_DO, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: reset register image
        rd();
        chk("t1_read", ibus.IBUS_DO, 32'h1800FF1F);

        // Test 2: interval overflow after 4 phi at /2
        wr16(A_CSR, 16'h5AFE);
        wr16(A_CSR, 16'hA520);
        idle(3);
        chk("t2_irq_before", 32'(wdt_irq), 32'h0);
        idle(1);
        chk("t2_irq_at_ovf", 32'(wdt_irq), 32'h1);

        // Test 3: OVF clear needs a prior read
        rd();
        chk("t3_read_ovf", 32'(ibus.IBUS_DO[31:24]), 32'hB8);
        wr16(A_CSR, 16'hA500);
        chk("t3_cleared", 32'(wdt_irq), 32'h0);
        wr16(A_CSR, 16'h5AFE);
        wr16(A_CSR, 16'hA520);
        idle(4);
        wr16(A_CSR, 16'hA500);
        chk("t3_not_cleared", 32'(wdt_irq), 32'h1);

        // Test 4: watchdog overflow pulses
        wr16(A_RST, 16'h5A40);
        wr16(A_CSR, 16'h5AFF);
        wr16(A_CSR, 16'hA560);
        lo_ovf = 0; lo_rst = 0; stop = 0; stopped = 0;
        for (int i = 0; i < 700; i++) begin
            if (stop && !stopped) begin wr16(A_CSR, 16'hA540); stopped = 1; end
            else idle(1);
            if (!wdtovf_n) begin lo_ovf++; stop = 1; end
            if (!wdt_rst_n) lo_rst++;
        end
        chk("t4_ovf_len", 32'(lo_ovf), 32'd128);
        chk("t4_rst_len", 32'(lo_rst), RESET_EN ? 32'd512 : 32'd0);
        rd();
        chk("t4_rstcsr", 32'(ibus.IBUS_DO[7:0]), RESET_EN ? 32'hDF : 32'h9F);
        wr16(A_RST, 16'hA500);
        rd();
        chk("t4_wovf_clr", 32'(ibus.IBUS_DO[7:0]), RESET_EN ? 32'h5F : 32'h1F);

        // Test 5: wrong password and byte write ignored
        phi(0, 0, A_CSR, 4'b0000, 32'h0, 0);
        wr16(A_CSR, 16'h1220);
        phi(1, 1, A_CSR, 4'b1000, 32'hA5200000, 1);
        rd();
        chk("t5_wtcsr", 32'(ibus.IBUS_DO[31:24]), 32'h18);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            rb = 8'($urandom_range(0, 255));
            if (r < 40) idle(1);
            else if (r < 52) rd();
            else if (r < 60) wr16(A_CSR, {8'hA5, rb & 8'hE1});
            else if (r < 68) wr16(A_CSR, {8'h5A, 8'($urandom_range(200, 255))});
            else if (r < 73) wr16(A_RST, 16'hA500);
            else if (r < 77) wr16(A_RST, {8'h5A, rb});
            else if (r < 82) wr16($urandom_range(0, 1) ? A_CSR : A_RST, {8'h33, rb});
            else if (r < 88) phi(1, 1, A_CSR, 4'b0001 << $urandom_range(0, 3),
                                 {8'hA5, rb, 8'h5A, rb}, 1);
            else if (r < 90) phi(0, 0, A_CSR, 4'b0000, 32'h0, 0);
            else if (r < 94) phi(1, 0, A_RST, 4'b0011, 32'h0, 1);
            else phi(1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) ? 28'h5FFFFBC : 28'h5FFFFB4,
                     4'b1111, {8'hA5, rb, 16'hA500}, 1);
        end

        // Test 6: WTCNT write beats a simultaneous overflowing increment at /8192
        phi(0, 0, A_CSR, 4'b0000, 32'h0, 0);
        wr16(A_CSR, 16'h5AFF);
        wr16(A_CSR, 16'hA527);
        idle(8191);
        wr16(A_CSR, 16'h5A10);
        rd();
        chk("t6_csr_cnt", 32'(ibus.IBUS_DO[31:16]), 32'h3F10);
        chk("t6_irq", 32'(wdt_irq), 32'h0);

        // Asynchronous reset in the middle of a WDTOVF_N pulse
        wr16(A_CSR, 16'h5AFF);
        wr16(A_CSR, 16'hA560);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            idle(1);
            if (!wdtovf_n) found = 1;
        end
        chk("ar_pulse_seen", 32'(found), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wdtovf_n", 32'(wdtovf_n), 32'h1);
        chk("ar_wdt_rst_n", 32'(wdt_rst_n), 32'h1);
        chk("ar_do", ibus.IBUS_DO, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd();
        chk("ar_read", ibus.IBUS_DO, 32'h1800FF1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sh7034_wdt.md
Name: sh7034_wdt

Overview:
- On-chip watchdog timer for the SH7034 core.
- Sits directly upstream of the interrupt controller and drives its WDT_IRQ input (interval-timer overflow, vector 112).
- In watchdog mode it drives the WDTOVF_N pin and, optionally, requests an internal power-on reset.
- Register access goes over the same internal 32-bit IBUS as the other peripherals.

Parameters:
- RST_PULSE, 512, length in φ cycles (CE_R pulses) of the internal reset request.
- OVF_PULSE, 128, length in φ cycles of the WDTOVF_N low pulse.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase enable; one pulse = one φ cycle
- CE_F  in  1  falling-phase enable
- RES_N  in  1  chip reset pin, sampled on CE_R
- IBUS_A  in  28  bus address
- IBUS_DI  in  32  write data
- IBUS_DO  out  32  read data
- IBUS_BA  in  4  byte enables; [3] = bits 31:24
- IBUS_WE  in  1  write strobe
- IBUS_REQ  in  1  access request
- IBUS_BUSY  out  1  always 0
- IBUS_ACT  out  1  high when 0x5FFFFB8 <= IBUS_A <= 0x5FFFFBB
- WDT_IRQ  out  1  interval interrupt request to the INTC (level)
- WDTOVF_N  out  1  overflow pin, active low
- WDT_RST_N  out  1  internal reset request, active low

Behaviour:
Clocking and reset:
- One clock (CLK); reset RST_N is asynchronous, active-low.
- Registers, counters and writes advance on CE_R. Read data is registered on CE_F.

Registers:
- WTCSR (0x5FFFFB8): bit7 OVF, bit6 WT/IT (1 = watchdog mode), bit5 TME, bits2:0 CKS. Reads bits4:3 as 1.
- WTCNT (0x5FFFFB9): 8-bit up-counter.
- RSTCSR (0x5FFFFBB): bit7 WOVF, bit6 RSTE, bit5 RSTS. Reads bits4:0 as 1.
- Reset values: WTCSR=0x18, WTCNT=0x00, RSTCSR=0x1F.
- Output reset values: WDT_IRQ=0, WDTOVF_N=1, WDT_RST_N=1, IBUS_DO=0.
- RES_N low: WTCSR, WTCNT, prescaler and RSTE/RSTS are initialised; WOVF is kept.

Writes (password protected, 16-bit only):
- Byte writes to this range are ignored.
- IBUS_BA[3:2]=11 with DI[31:24]=0xA5: WTCSR <= DI[23:16].
- IBUS_BA[3:2]=11 with DI[31:24]=0x5A: WTCNT <= DI[23:16].
- IBUS_BA[1:0]=11 with DI[15:8]=0xA5 and DI[7:0]=0x00: clear WOVF.
- IBUS_BA[1:0]=11 with DI[15:8]=0x5A: RSTE/RSTS <= DI[6:5].
- Any other password value: no effect.
- OVF clears only when written 0 after a read returned OVF=1; an internal read-flag arms on that read and clears after any WTCSR write. Writing 1 to OVF never sets it.

Reads:
- On CE_F with REG_SEL & !WE & REQ:
  - IBUS_DO = {WTCSR, WTCNT, 0xFF, RSTCSR} for word offset 8.
  - IBUS_DO = 0 otherwise.
- IBUS_DO holds its value between reads.

Counting:
- 13-bit prescaler counts CE_R pulses while TME=1. It is held at 0 while TME=0.
- CKS selects the divider: 0:/2, 1:/64, 2:/128, 3:/256, 4:/512, 5:/1024, 6:/4096, 7:/8192.
- WTCNT increments on the CE_R where the selected prescaler bit has a falling transition.
- WTCNT holds its value when TME=0.
- Overflow = increment from 0xFF to 0x00.
- Writing CKS while running restarts the prescaler at 0.

Overflow handling:
- Interval mode (WT/IT=0): set OVF. WDT_IRQ = OVF & ~WT/IT, combinational from the register; the INTC sees it on the next CE_R.
- Watchdog mode: set WOVF and drive WDTOVF_N low for OVF_PULSE φ cycles. The pulse starts the CE_R after overflow.
- A new overflow during an active pulse restarts the pulse length.

Simultaneous events:
- WTCNT write and increment in the same cycle: the write wins, no overflow.
- OVF set and OVF clear in the same cycle: set wins.
- Mode switch to interval while OVF=1: WDT_IRQ asserts immediately.
- RST_N mid-pulse: WDTOVF_N and WDT_RST_N go high asynchronously.

Optional Feature:
- Macro: SH7034_WDT_RESET_EN.
- Defined: on a watchdog-mode overflow with RSTE=1, WDT_RST_N goes low for RST_PULSE φ cycles, starting with the WDTOVF_N pulse. RSTS is readable but has no effect on behaviour; manual and power-on resets are treated alike. The pulse is not cancelled by RES_N and is not retriggered while active.
- Undefined: RSTE/RSTS read as 0, writes to them are ignored, WDT_RST_N is tied to 1.

Test Plan:
1. After RST_N, read 0x5FFFFB8 -> IBUS_DO=0x1800FF1F; WDT_IRQ=0, WDTOVF_N=1.
2. Write WTCNT=0xFE (0x5AFE), then WTCSR=0x20 (TME, interval, /2) -> WTCNT reaches 0x00 after 4 φ; OVF=1 and WDT_IRQ=1 on that edge.
3. From test 2: read WTCSR, then write 0xA500 -> OVF=0, WDT_IRQ=0. Writing 0xA500 without the prior read -> OVF stays 1.
4. Write 0x5A40 to offset BA, WTCNT=0xFF, WTCSR=0x60 -> at overflow WOVF=1, WDTOVF_N low exactly 128 φ; with SH7034_WDT_RESET_EN, WDT_RST_N low exactly 512 φ.
5. Wrong password 0x1220 to WTCSR, plus a byte write to 0x5FFFFB8 -> WTCSR unchanged at 0x18.
6. Counter running at CKS=7: write WTCNT=0x10 on the CE_R of an increment -> WTCNT=0x10, no overflow; read 0x5FFFFB8 shows 0x10 in bits 23:16.
